// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared widths and word type for the 16-bit carry-lookahead adder
package cla_pkg;
  localparam int unsigned CLA_WIDTH = 16;
  localparam int unsigned CLA_GRP_W = 4;
  localparam int unsigned CLA_NGRP  = 4;

  typedef logic [CLA_WIDTH-1:0] cla_word_t;
endpackage

// File: rtl/cla_4bit.sv
// rtl/cla_4bit.sv - combinational 4-bit lookahead group: sum bits plus group propagate/generate
module cla_4bit
  import cla_pkg::*;
(
  input  logic [CLA_GRP_W-1:0] a,
  input  logic [CLA_GRP_W-1:0] b,
  input  logic                 ci,
  output logic [CLA_GRP_W-1:0] s,
  output logic                 gp,
  output logic                 gg
);

  logic [CLA_GRP_W-1:0] p;
  logic [CLA_GRP_W-1:0] g;
  logic [CLA_GRP_W-1:0] c;

  always_comb begin
    p = a ^ b;
    g = a & b;

    // Every in-group carry is a flat sum of products of p, g and ci.
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    s  = p ^ c;
    gp = &p;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// File: rtl/carry_lookahead_16bit.sv
// rtl/carry_lookahead_16bit.sv - registered 16-bit two-level CLA adder; CLA_OVERFLOW_EN adds the ovf output
module carry_lookahead_16bit
  import cla_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CLA_WIDTH-1:0] a,
  input  logic [CLA_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [CLA_WIDTH-1:0] sum,
`ifdef CLA_OVERFLOW_EN
  output logic                 cout,
  output logic                 ovf
`else
  output logic                 cout
`endif
);

  logic [CLA_NGRP-1:0] gp;
  logic [CLA_NGRP-1:0] gg;
  logic [CLA_NGRP:0]   gc;
  cla_word_t           sum_d, sum_q;
  logic                cout_d, cout_q;

  for (genvar k = 0; k < CLA_NGRP; k++) begin : g_grp
    cla_4bit u_grp (
      .a  (a[k*CLA_GRP_W +: CLA_GRP_W]),
      .b  (b[k*CLA_GRP_W +: CLA_GRP_W]),
      .ci (gc[k]),
      .s  (sum_d[k*CLA_GRP_W +: CLA_GRP_W]),
      .gp (gp[k]),
      .gg (gg[k])
    );
  end

  // Second-level lookahead: group carries never wait on a lower group's carry.
  always_comb begin
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    cout_d = gc[4];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef CLA_OVERFLOW_EN
  logic ovf_d, ovf_q;

  // Carry into bit 15 is recovered from that bit's sum and propagate.
  always_comb begin
    ovf_d = (a[CLA_WIDTH-1] ^ b[CLA_WIDTH-1] ^ sum_d[CLA_WIDTH-1]) ^ cout_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_carry_lookahead_16bit.sv
// tb/tb_carry_lookahead_16bit.sv - self-checking bench for carry_lookahead_16bit against an arithmetic model
module tb_carry_lookahead_16bit;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;
`ifdef CLA_OVERFLOW_EN
  logic        ovf;
`endif

  int pass_cnt;
  int total_cnt;

  carry_lookahead_16bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
`ifdef CLA_OVERFLOW_EN
    .cout  (cout),
    .ovf   (ovf)
`else
    .cout  (cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic c);
    int unsigned total;
    total = int'(x) + int'(y) + (c ? 1 : 0);
    return total[16:0];
  endfunction

  // Signed overflow: operands share a sign and the result's sign differs.
  function automatic logic ref_ovf(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] r;
    r = ref_add(x, y, c);
    return (x[15] == y[15]) && (r[15] != x[15]);
  endfunction

  task automatic drive(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc);
    a   = ta;
    b   = tb_v;
    cin = tc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(16'hFFFF, 16'h0001, 1'b0);
      total_cnt++;
      if ({cout, sum} !== 17'h0_0000) $display("FAIL reset_hold cyc%0d: got %h want 00000", i, {cout, sum});
      else pass_cnt++;
`ifdef CLA_OVERFLOW_EN
      total_cnt++;
      if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf);
      else pass_cnt++;
`endif
    end
    rst_n = 1'b1;
    drive(16'hFFFF, 16'h0001, 1'b0);
    total_cnt++;
    if ({cout, sum} !== 17'h1_0000) $display("FAIL reset_release: got %h want 10000", {cout, sum});
    else pass_cnt++;
  endtask

  task automatic test_directed;
    logic [15:0] va [6] = '{16'd0, 16'd14, 16'd5, 16'd999, 16'hFFFF, 16'h8000};
    logic [15:0] vb [6] = '{16'd0, 16'd1,  16'd0, 16'd0,   16'd0,    16'h8000};
    logic        vc [6] = '{1'b1,  1'b1,   1'b0,  1'b1,    1'b1,     1'b0};
    logic [16:0] want [6] = '{17'd1, 17'd16, 17'd5, 17'd1000, 17'h1_0000, 17'h1_0000};
    for (int i = 0; i < 6; i++) begin
      drive(va[i], vb[i], vc[i]);
      total_cnt++;
      if ({cout, sum} !== want[i])
        $display("FAIL directed%0d a=%h b=%h cin=%b: got %h want %h", i, va[i], vb[i], vc[i], {cout, sum}, want[i]);
      else pass_cnt++;
`ifdef CLA_OVERFLOW_EN
      total_cnt++;
      if (ovf !== (i == 5)) $display("FAIL directed_ovf%0d: got %b want %b", i, ovf, (i == 5));
      else pass_cnt++;
`endif
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] prev;
    drive(16'h1234, 16'h4321, 1'b0);
    prev = ref_add(16'h1234, 16'h4321, 1'b0);
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if ({cout, sum} !== prev) $display("FAIL b2b%0d: got %h want %h", i, {cout, sum}, prev);
      else pass_cnt++;
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      drive(ra, rb, rc);
      prev = ref_add(ra, rb, rc);
    end
    // Outputs must hold between edges.
    @(negedge clk);
    total_cnt++;
    if ({cout, sum} !== prev) $display("FAIL hold: got %h want %h", {cout, sum}, prev);
    else pass_cnt++;
    #1;
  endtask

  task automatic test_random;
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] want;
    for (int i = 0; i < 10000; i++) begin
      if (i == 0) begin
        ra = 16'h7FFF; rb = 16'h0001; rc = 1'b0;
      end else begin
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
        if ((i % 16) == 1) rb = ~ra;
      end
      drive(ra, rb, rc);
      want = ref_add(ra, rb, rc);
      total_cnt++;
      if ({cout, sum} !== want)
        $display("FAIL random%0d a=%h b=%h cin=%b: got %h want %h", i, ra, rb, rc, {cout, sum}, want);
      else pass_cnt++;
`ifdef CLA_OVERFLOW_EN
      total_cnt++;
      if (ovf !== ref_ovf(ra, rb, rc))
        $display("FAIL random_ovf%0d a=%h b=%h: got %b want %b", i, ra, rb, ovf, ref_ovf(ra, rb, rc));
      else pass_cnt++;
`endif
    end
  endtask

  task automatic test_reset_priority;
    rst_n = 1'b0;
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    total_cnt++;
    if ({cout, sum} !== 17'h0_0000) $display("FAIL reset_priority: got %h want 00000", {cout, sum});
    else pass_cnt++;
    rst_n = 1'b1;
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    total_cnt++;
    if ({cout, sum} !== 17'h1_FFFF) $display("FAIL post_reset_op: got %h want 1ffff", {cout, sum});
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    a     = 16'hFFFF;
    b     = 16'h0001;
    cin   = 1'b0;
    #2;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_priority();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
